// File: rtl/byte_encode_stream_if.sv
// Handshake bundle for byte_encode_stream: coefficient stream in, packed byte stream out.
interface byte_encode_stream_if;
  logic        coef_valid;
  logic [11:0] coef;
  logic        coef_ready;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        byte_ready;

  modport master (
    output coef_valid, coef, byte_ready,
    input  coef_ready, byte_valid, byte_out
  );

  modport slave (
    input  coef_valid, coef, byte_ready,
    output coef_ready, byte_valid, byte_out
  );
endinterface

// File: rtl/byte_encode_stream.sv
// Packs D-bit coefficients LSB-first into a byte stream through a 20-bit accumulator.
// Optional macro BYTE_ENCODE_MODQ_EN: coefficients >= 3329 are reduced by 3329 before packing.
module byte_encode_stream #(
  parameter int D      = 12,
  parameter int N_COEF = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  byte_encode_stream_if.slave  s,
  output logic                 busy,
  output logic                 done
);
  localparam int N_BYTES = (N_COEF * D) / 8;
  localparam int CW      = $clog2(N_COEF + 1);
  localparam int BW      = $clog2(N_BYTES + 1);

  localparam logic [CW-1:0] N_COEF_C    = CW'(N_COEF);
  localparam logic [BW-1:0] LAST_BYTE_C = BW'(N_BYTES - 1);
  localparam logic [4:0]    D_C         = 5'(D);
  localparam logic [19:0]   COEF_MASK   = 20'((1 << D) - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [19:0]   acc_q, acc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [CW-1:0] ncoef_q, ncoef_d;
  logic [BW-1:0] nbyte_q, nbyte_d;

  logic [11:0] coef_red_s;
  logic [19:0] coef_ext_s;
  logic [19:0] acc_sh_s;
  logic [4:0]  cnt_sh_s;
  logic        coef_hs_s;
  logic        byte_hs_s;

  // All outputs derive from registered state only, so coef never reaches byte_out combinationally.
  assign s.coef_ready = (state_q == ST_RUN) && (cnt_q < 5'd8) && (ncoef_q < N_COEF_C);
  assign s.byte_valid = (state_q == ST_RUN) && (cnt_q >= 5'd8);
  assign s.byte_out   = acc_q[7:0];
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

  assign coef_hs_s = s.coef_valid && s.coef_ready;
  assign byte_hs_s = s.byte_valid && s.byte_ready;

`ifdef BYTE_ENCODE_MODQ_EN
  // Conditional subtract of q brings [0, 2q) into [0, q).
  always_comb begin
    if (s.coef >= 12'd3329) begin
      coef_red_s = s.coef - 12'd3329;
    end else begin
      coef_red_s = s.coef;
    end
  end
`else
  assign coef_red_s = s.coef;
`endif

  assign coef_ext_s = {8'd0, coef_red_s} & COEF_MASK;

  // Next-state: byte drain happens first, so a same-cycle insert lands at cnt-8.
  always_comb begin
    acc_sh_s = byte_hs_s ? {8'd0, acc_q[19:8]} : acc_q;
    cnt_sh_s = byte_hs_s ? (cnt_q - 5'd8) : cnt_q;
    state_d  = state_q;
    acc_d    = acc_sh_s;
    cnt_d    = cnt_sh_s;
    ncoef_d  = ncoef_q + {{(CW-1){1'b0}}, coef_hs_s};
    nbyte_d  = nbyte_q + {{(BW-1){1'b0}}, byte_hs_s};
    if (coef_hs_s) begin
      acc_d = acc_sh_s | (coef_ext_s << cnt_sh_s);
      cnt_d = cnt_sh_s + D_C;
    end else begin
      acc_d = acc_sh_s;
      cnt_d = cnt_sh_s;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          acc_d   = 20'd0;
          cnt_d   = 5'd0;
          ncoef_d = '0;
          nbyte_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (byte_hs_s && (nbyte_q == LAST_BYTE_C)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 20'd0;
      cnt_q   <= 5'd0;
      ncoef_q <= '0;
      nbyte_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ncoef_q <= ncoef_d;
      nbyte_q <= nbyte_d;
    end
  end
endmodule
